// File: rtl/alureg_bank.sv
// Register bank with an in-place ALU write port and two read ports.
// Zero/carry flags track the most recent non-HOLD write.
module alureg_bank #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic              zero,
    output logic              carry
);

    localparam int NREG = 2 ** ADDR_W;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_ADD   = 3'b111;

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             wr;

    assign cur = regs[waddr];
    assign ext = {1'b0, cur};
    assign wr  = we && (op != OP_HOLD);

    always_comb begin
        res   = cur;
        res_c = 1'b0;
        unique case (op)
            OP_HOLD: begin
                res   = cur;
                res_c = 1'b0;
            end
            OP_LOAD: begin
                res   = in;
                res_c = 1'b0;
            end
            OP_CLEAR: begin
                res   = '0;
                res_c = 1'b0;
            end
            OP_INC: begin
                {res_c, res} = ext + (WIDTH+1)'(1);
            end
            OP_DEC: begin
                res   = cur - WIDTH'(1);
                res_c = (cur == '0);
            end
            OP_SHL: begin
                res   = {cur[WIDTH-2:0], 1'b0};
                res_c = cur[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, cur[WIDTH-1:1]};
                res_c = cur[0];
            end
            OP_ADD: begin
                {res_c, res} = ext + {1'b0, in};
            end
            default: begin
                res   = cur;
                res_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            zero  <= 1'b0;
            carry <= 1'b0;
        end else if (wr) begin
            regs[waddr] <= res;
            zero        <= (res == '0);
            carry       <= res_c;
        end
    end

    // Bypass is masked during reset so outputs read zero immediately.
    always_comb begin
        out_a = regs[raddr_a];
        out_b = regs[raddr_b];
        if (BYPASS != 0 && wr && !rst) begin
            if (raddr_a == waddr) out_a = res;
            if (raddr_b == waddr) out_b = res;
        end
    end

endmodule
